// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data memory request arbiter.
// Master IDs, transfer size encodings and the default outstanding depth.
package mem_arb_pkg;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int unsigned DEPTH_DEFAULT = 2;

endpackage

// File: rtl/owner_fifo.sv
// Order-preserving FIFO of 1-bit master IDs, one entry per slave transaction in flight.
// Pushes while full and pops while empty are ignored.
module owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_push_id,
  input  logic          i_pop,
  output logic          o_head,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & (r_count != CW'(DEPTH));
  assign w_pop  = i_pop & (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_id;
        r_wptr        <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction and data SRAM-like masters onto one slave, data side first.
// An offered-but-unaccepted request is locked so the slave sees a stable request.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [3:0]  i_wstrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        err_unexp
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          r_lock_vld;
  logic          r_lock_id;
  logic          r_err_unexp;
  logic          w_lock_vld_d;
  logic          w_lock_id_d;
  logic          w_sel;
  logic          w_not_full;
  logic          w_accept;
  logic          w_pop;
  logic          w_head;
  logic [CW-1:0] w_count;

  assign w_sel      = r_lock_vld ? r_lock_id : (d_req ? ID_DATA : ID_INST);
  assign w_not_full = (w_count < CW'(DEPTH));
  assign s_req      = r_lock_vld | ((d_req | i_req) & w_not_full);
  assign w_accept   = s_req & s_addr_ok;
  assign w_pop      = s_data_ok & (w_count != '0);

  always_comb begin
    if (w_sel == ID_DATA) begin
      s_wr    = d_wr;
      s_size  = d_size;
      s_wstrb = d_wstrb;
      s_addr  = d_addr;
      s_wdata = d_wdata;
    end else begin
      s_wr    = i_wr;
      s_size  = i_size;
      s_wstrb = i_wstrb;
      s_addr  = i_addr;
      s_wdata = i_wdata;
    end
  end

  always_comb begin
    w_lock_vld_d = r_lock_vld;
    w_lock_id_d  = r_lock_id;
    if (w_accept) begin
      w_lock_vld_d = 1'b0;
    end else if (s_req && !r_lock_vld) begin
      w_lock_vld_d = 1'b1;
      w_lock_id_d  = w_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_vld  <= 1'b0;
      r_lock_id   <= ID_INST;
      r_err_unexp <= 1'b0;
    end else begin
      r_lock_vld <= w_lock_vld_d;
      r_lock_id  <= w_lock_id_d;
      if (s_data_ok && (w_count == '0)) begin
        r_err_unexp <= 1'b1;
      end
    end
  end

  owner_fifo #(
    .DEPTH (DEPTH)
  ) u_owner_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_accept),
    .i_push_id (w_sel),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  assign i_addr_ok = w_accept & (w_sel == ID_INST);
  assign d_addr_ok = w_accept & (w_sel == ID_DATA);
  assign i_data_ok = w_pop & (w_head == ID_INST);
  assign d_data_ok = w_pop & (w_head == ID_DATA);
  assign i_rdata   = s_rdata;
  assign d_rdata   = s_rdata;
  assign err_unexp = r_err_unexp;

endmodule
